// File: rtl/alu_share_arb.sv
// Two-port round-robin arbiter sharing one 32-bit integer ALU.
// One operation in flight at a time: IDLE accepts, EXEC computes, RESP holds the result.
module alu_share_arb #(
    parameter bit FAIR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_op,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_data,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_data,
    input  logic        rsp1_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_owner;
    logic        r_last_grant;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [2:0]  r_op;
    logic [31:0] r_rsp0_data;
    logic [31:0] r_rsp1_data;

    logic        w_grant;
    logic        w_accept;
    logic        w_rsp_ready;
    logic [31:0] w_alu;

    // Op 5 is reserved and deliberately yields zero.
    function automatic logic [31:0] alu_eval(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [2:0]  op);
        logic [31:0] res;
        res = 32'h0;
        case (op)
            3'd0:    res = a + b;
            3'd1:    res = a + ~b + 32'd1;
            3'd2:    res = a & b;
            3'd3:    res = a | b;
            3'd4:    res = a ^ b;
            3'd6:    res = a << b[4:0];
            3'd7:    res = a >> b[4:0];
            default: res = 32'h0;
        endcase
        return res;
    endfunction

    assign w_alu = alu_eval(r_a, r_b, r_op);

    // Grant 1 selects requester 1; a lone valid requester always wins.
    always_comb begin
        w_grant = 1'b0;
        if (FAIR && req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else begin
            w_grant = ~req0_valid;
        end
    end

    assign w_accept    = (r_state == S_IDLE) && (req0_valid || req1_valid);
    assign req0_ready  = w_accept && !w_grant;
    assign req1_ready  = w_accept && w_grant;
    assign w_rsp_ready = r_owner ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_RESP;
            S_RESP:  if (w_rsp_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Operands are captured only on the accept edge; later request changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_a          <= 32'h0;
            r_b          <= 32'h0;
            r_op         <= 3'd0;
            r_rsp0_data  <= 32'h0;
            r_rsp1_data  <= 32'h0;
        end else begin
            if (w_accept) begin
                r_owner      <= w_grant;
                r_last_grant <= w_grant;
                r_a          <= w_grant ? req1_a  : req0_a;
                r_b          <= w_grant ? req1_b  : req0_b;
                r_op         <= w_grant ? req1_op : req0_op;
            end
            if (r_state == S_EXEC) begin
                if (r_owner) begin
                    r_rsp1_data <= w_alu;
                end else begin
                    r_rsp0_data <= w_alu;
                end
            end
        end
    end

    assign rsp0_valid = (r_state == S_RESP) && !r_owner;
    assign rsp1_valid = (r_state == S_RESP) && r_owner;
    assign rsp0_data  = r_rsp0_data;
    assign rsp1_data  = r_rsp1_data;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: single ops, op sweep, contention,
// backpressure, operand stability and reset during a response.
module tb_alu_share_arb;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_data, rsp1_data;
    logic        rsp0_ready, rsp1_ready;
    logic        busy;

    int checkCount = 0;
    int errorCount = 0;

    alu_share_arb #(.FAIR(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .rsp1_ready (rsp1_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input logic valid, input logic [31:0] a,
                                 input logic [31:0] b, input logic [2:0] op);
        if (port == 0) begin
            req0_valid = valid; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = valid; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    // One isolated operation on a single port; result visible two cycles after accept.
    task automatic doOp(input int port, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [31:0] expected, input string tag);
        @(negedge clk);
        applyStimulus(port, 1'b1, a, b, op);
        #1;
        checkOutput({tag, "_ready"}, (port == 0) ? req0_ready : req1_ready, 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        #1;
        checkOutput({tag, "_exec_busy"}, busy, 32'd1);
        checkOutput({tag, "_exec_valid"}, (port == 0) ? rsp0_valid : rsp1_valid, 32'd0);
        @(negedge clk);
        checkOutput({tag, "_valid"}, (port == 0) ? rsp0_valid : rsp1_valid, 32'd1);
        checkOutput({tag, "_data"}, (port == 0) ? rsp0_data : rsp1_data, expected);
        if (port == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        @(negedge clk);
        checkOutput({tag, "_done_valid"}, (port == 0) ? rsp0_valid : rsp1_valid, 32'd0);
        checkOutput({tag, "_done_busy"}, busy, 32'd0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    // Both requesters held valid; entered at a negedge in IDLE, leaves at a negedge in IDLE.
    task automatic contendRound(input int owner, input logic [31:0] expected, input string tag);
        #1;
        checkOutput({tag, "_rdy0"}, req0_ready, (owner == 0) ? 32'd1 : 32'd0);
        checkOutput({tag, "_rdy1"}, req1_ready, (owner == 1) ? 32'd1 : 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_exec_rdy"}, {30'd0, req1_ready, req0_ready}, 32'd0);
        @(negedge clk);
        checkOutput({tag, "_v0"}, rsp0_valid, (owner == 0) ? 32'd1 : 32'd0);
        checkOutput({tag, "_v1"}, rsp1_valid, (owner == 1) ? 32'd1 : 32'd0);
        checkOutput({tag, "_data"}, (owner == 0) ? rsp0_data : rsp1_data, expected);
        if (owner == 0) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        @(negedge clk);
        checkOutput({tag, "_ignored_rdy"}, (owner == 0) ? rsp0_valid : rsp1_valid, 32'd1);
        checkOutput({tag, "_resp_rdy"}, {30'd0, req1_ready, req0_ready}, 32'd0);
        rsp0_ready = (owner == 0);
        rsp1_ready = (owner == 1);
        @(negedge clk);
        checkOutput({tag, "_consumed"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        applyStimulus(0, 1'b0, 32'h0, 32'h0, 3'd0);
        applyStimulus(1, 1'b0, 32'h0, 32'h0, 3'd0);
        repeat (2) @(negedge clk);
        checkOutput("reset_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        checkOutput("reset_rspv", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        checkOutput("reset_data0", rsp0_data, 32'h0);
        checkOutput("reset_data1", rsp1_data, 32'h0);
        checkOutput("reset_busy", busy, 32'd0);
        rst = 1'b0;

        $display("[TB] single ops on port 0");
        doOp(0, 32'h7FFF_FFFF, 32'h1, 3'd0, 32'h8000_0000, "add_wrap");
        doOp(0, 32'h0, 32'h1, 3'd1, 32'hFFFF_FFFF, "sub_wrap");

        $display("[TB] op sweep on port 1");
        doOp(1, 32'hF0F0_1234, 32'h24, 3'd0, 32'hF0F0_1258, "sw_add");
        doOp(1, 32'hF0F0_1234, 32'h24, 3'd1, 32'hF0F0_1210, "sw_sub");
        doOp(1, 32'hF0F0_1234, 32'h24, 3'd2, 32'h0000_0024, "sw_and");
        doOp(1, 32'hF0F0_1234, 32'h24, 3'd3, 32'hF0F0_1234, "sw_or");
        doOp(1, 32'hF0F0_1234, 32'h24, 3'd4, 32'hF0F0_1210, "sw_xor");
        doOp(1, 32'hF0F0_1234, 32'h24, 3'd6, 32'h0F01_2340, "sw_sll");
        doOp(1, 32'hF0F0_1234, 32'h24, 3'd7, 32'h0F0F_0123, "sw_srl");
        doOp(1, 32'hF0F0_1234, 32'h24, 3'd5, 32'h0000_0000, "sw_rsvd");

        $display("[TB] contention, both requesters valid");
        @(negedge clk);
        applyStimulus(0, 1'b1, 32'd3, 32'd4, 3'd0);
        applyStimulus(1, 1'b1, 32'hFF, 32'h0F, 3'd4);
        contendRound(0, 32'd7, "rr_a");
        contendRound(1, 32'hF0, "rr_b");
        contendRound(0, 32'd7, "rr_c");
        contendRound(1, 32'hF0, "rr_d");
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        $display("[TB] response backpressure");
        @(negedge clk);
        applyStimulus(0, 1'b1, 32'h100, 32'h23, 3'd0);
        #1;
        checkOutput("bp_accept", req0_ready, 32'd1);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(0, 1'b0, 32'h0, 32'h0, 3'd0);
        applyStimulus(1, 1'b1, 32'hFF, 32'h0F, 3'd2);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid", rsp0_valid, 32'd1);
            checkOutput("bp_data", rsp0_data, 32'h123);
            checkOutput("bp_holdoff", req1_ready, 32'd0);
            checkOutput("bp_busy", busy, 32'd1);
            @(negedge clk);
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        checkOutput("bp_released", rsp0_valid, 32'd0);
        #1;
        checkOutput("bp_req1_grant", req1_ready, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        checkOutput("bp_req1_valid", rsp1_valid, 32'd1);
        checkOutput("bp_req1_data", rsp1_data, 32'h0F);
        rsp1_ready = 1'b1;
        @(negedge clk);
        rsp1_ready = 1'b0;
        checkOutput("bp_req1_done", rsp1_valid, 32'd0);

        $display("[TB] operand stability");
        @(negedge clk);
        applyStimulus(0, 1'b1, 32'd5, 32'd6, 3'd0);
        #1;
        checkOutput("stab_accept", req0_ready, 32'd1);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(0, 1'b0, 32'hDEAD_BEEF, 32'h1000, 3'd4);
        @(negedge clk);
        checkOutput("stab_valid", rsp0_valid, 32'd1);
        checkOutput("stab_data", rsp0_data, 32'd11);
        rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;

        $display("[TB] reset while a response is pending");
        @(negedge clk);
        applyStimulus(1, 1'b1, 32'd10, 32'd3, 3'd1);
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_pre_valid", rsp1_valid, 32'd1);
        checkOutput("rst_pre_data", rsp1_data, 32'd7);
        rst = 1'b1;
        #1;
        checkOutput("rst_async_valid", rsp1_valid, 32'd0);
        checkOutput("rst_async_busy", busy, 32'd0);
        checkOutput("rst_async_data1", rsp1_data, 32'h0);
        checkOutput("rst_async_data0", rsp0_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 1'b1, 32'd3, 32'd4, 3'd0);
        applyStimulus(1, 1'b1, 32'hFF, 32'h0F, 3'd4);
        contendRound(0, 32'd7, "post_rst_a");
        contendRound(1, 32'hF0, "post_rst_b");
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
